rv32i_soc_sys: RTL and testbench
================================

# rv32i_soc_sys

Self-contained RV32I system: a multi-cycle RV32I integer core (`m0`), a word-organised instruction ROM (`m1`) and a byte-maskable data RAM (`m2`) on separate instruction and data buses. It is the top level for simulation-based ISA testing. Program and data images are preloaded into the memories. The core runs from `PC_RESET` until it executes `ebreak`, then halts permanently.

## Interface
- `PC_RESET`, default 32'h0000_0000, program counter value after reset.
- `ROM_DEPTH`, default 8192, instruction memory size in bytes (ROM_DEPTH/4 words).
- `RAM_DEPTH`, default 8192, data memory size in bytes (RAM_DEPTH/4 words).
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous reset, **active-high**. The port keeps the codebase name; it is asserted at 1.

## Operation
- **Hierarchy names.** Verification probes these by name:
  - `m0.inst_q`: current instruction register.
  - `m0.m0.base_regfile[0:31]`, plus write strobe `m0.m0.wr`, `m0.m0.rd_addr`, `m0.m0.rd`.
  - `m1.inst_regfile[word]`.
  - `m2.data_regfile[word]`, plus `m2.wr_en`, `m2.addr`, `m2.data_in`, `m2.wr_mask[3:0]`.
- **Memory maps.**
  - ROM is indexed by `pc[..:2]`, modulo ROM_DEPTH/4.
  - RAM is indexed by `addr[..:2]`, modulo RAM_DEPTH/4. Byte address 0x1000 maps to `data_regfile[0x400]`.
  - Neither memory is reset; contents come from preload or program stores.
- **ISA.** Full RV32I base:
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU and SB/SH/SW.
  - All OP-IMM and OP ops, with shifts using the low 5 bits.
- **Other opcodes.**
  - FENCE, ECALL and all SYSTEM/CSR encodings other than EBREAK execute as NOP, advancing PC by 4.
  - Unknown opcodes also execute as NOP.
- **x0.** Register x0 always reads 0. Writes with `rd_addr==0` are discarded.
- **Stores.**
  - Byte lane = `addr[1:0]`; `wr_mask` selects the lanes.
  - SB: data byte replicated to all lanes, mask `0001 << addr[1:0]`.
  - SH: data halfword replicated, mask `0011 << {addr[1],0}`.
  - SW: mask `1111`.
  - Misalignment is not trapped; low address bits beyond the lane select are ignored.
- **Loads.** The selected byte or halfword is extracted from the word, then sign- or zero-extended.
- **EBREAK (0x00100073).**
  - The core enters HALT. `inst_q` keeps 0x00100073 indefinitely.
  - No further register or memory writes occur until reset.

## Timing
- **Reset state** (asynchronous, while `rst_n`=1):
  - PC=PC_RESET and `inst_q`=0x00000013 (NOP).
  - All 32 registers = 0.
  - `wr`=0 and `wr_en`=0.
  - FSM in FETCH.
- **FSM states.**
  - FETCH: synchronous ROM read; `inst_q` is loaded at the clock edge. Next state EXEC.
  - EXEC:
    - Performs ALU, branch and jump work.
    - Register write (`wr`=1) for non-load instructions with a destination register.
    - RAM write: `wr_en`=1 for one cycle with `addr`, `data_in`, `wr_mask` valid.
    - PC update.
    - Next state is LOAD for loads, HALT for EBREAK, otherwise FETCH.
  - LOAD: synchronous RAM read data available; register write-back (`wr`=1). Next state FETCH.
  - HALT: terminal; exited only by reset.
- **Latency.**
  - Loads take 3 cycles; all other instructions take 2.
  - A store is visible to a load issued in the next instruction.
  - A register written in EXEC or LOAD is visible to the next instruction.
- **Strobes.** `wr` and `wr_en` are high only in their write cycle and never high simultaneously for one instruction.
- **Reset mid-instruction.** Any in-flight write is aborted. Execution restarts at PC_RESET. Memory contents are retained.

## Test plan
- **Reset:** hold `rst_n`=1 for 5 cycles, then release. Expect no `wr`/`wr_en` pulses during reset, all registers 0, and the first fetch from address PC_RESET=0.
- **ALU:** program `addi x1,x0,5; addi x2,x1,-7; sltu x3,x1,x2; srai x4,x2,1; ebreak`. Expect x1=5, x2=0xFFFFFFFE, x3=1, x4=0xFFFFFFFF; `inst_q` stays 0x00100073 and there are no further writes.
- **Memory:**
  - `lui x5,0x1` then store x6=0x12345678 with `sw 0(x5)`: expect `data_regfile[0x400]`=0x12345678, mask 1111.
  - `sb` of 0xAB at 0x1001: expect mask 0010 and the word becomes 0x1234AB78.
  - `lb` from 0x1001 returns 0xFFFFFFAB; `lbu` returns 0x000000AB; `lh` from 0x1002 returns 0x00001234.
- **Control flow:**
  - Taken `beq` skips the next instruction; a not-taken `bne` falls through.
  - `jal x1,+8` at PC 0x10 gives x1=0x14 and PC=0x18.
  - `jalr` to an odd target clears bit 0.
- **Compliance-style exit:** run a preloaded program ending with x17=0x5d and x10=0, then `ebreak`. Expect halt with x17=0x0000005d and x10=0, which counts as PASS. Running with a nonzero x10 reports FAIL with code x10>>1.
- **Mid-run reset:** assert `rst_n` during a LOAD cycle. Expect the write-back to be suppressed, registers cleared, and re-execution from PC_RESET producing identical results.

Source files
------------

// File: rtl/rv32i_soc_sys.sv
// rv32i_soc_sys: multi-cycle RV32I core (m0) with an instruction ROM (m1) and a
// byte-maskable data RAM (m2) on separate buses. rst_n is asserted high.

module rv32i_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] base_regfile [0:31];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) base_regfile[i] <= '0;
    end else if (wr && rd_addr != 5'd0) begin
      base_regfile[rd_addr] <= rd;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : base_regfile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : base_regfile[rs2_addr];
endmodule

module rv32i_rom #(
  parameter int ROM_DEPTH = 8192
) (
  input  logic [31:0] pc,
  output logic [31:0] inst
);
  localparam int AW = $clog2(ROM_DEPTH / 4);
  logic [31:0] inst_regfile [0:ROM_DEPTH/4-1];
  logic        unused_pc_bits;

  assign inst           = inst_regfile[pc[AW+1:2]];
  assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};
endmodule

module rv32i_ram #(
  parameter int RAM_DEPTH = 8192
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  wr_mask,
  output logic [31:0] data_out
);
  localparam int AW = $clog2(RAM_DEPTH / 4);
  logic [31:0]   data_regfile [0:RAM_DEPTH/4-1];
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // NOTE: memory arrays get no reset; contents survive reset and come from preload or stores.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) data_regfile[idx][8*b +: 8] <= data_in[8*b +: 8];
    end
    data_out <= data_regfile[idx];
  end
endmodule

module rv32i_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] addr,
  output logic [31:0] data_in,
  output logic [3:0]  wr_mask,
  output logic        wr_en,
  input  logic [31:0] data_out
);
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, LOAD = 2'd2, HALT = 2'd3;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13,
                         OP_OP = 7'h33;
  localparam logic [31:0] NOP = 32'h0000_0013, EBREAK = 32'h0010_0073;

  logic [1:0]  state;
  logic [31:0] inst_q, pc_q;
  logic [31:0] rs1_v, rs2_v, rd_val, rd_data, ld_data, alu_b, alu_y, pc_next;
  logic [31:0] lane_b, lane_h;
  logic        rd_wr, taken, wr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst_q[6:0];
  assign f3     = inst_q[14:12];
  assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s  = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b  = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u  = {inst_q[31:12], 12'h000};
  assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  rv32i_regfile m0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd_addr(inst_q[11:7]), .rd(rd_val),
    .rs1_addr(inst_q[19:15]), .rs2_addr(inst_q[24:20]), .rs1_data(rs1_v), .rs2_data(rs2_v)
  );

  assign pc   = pc_q;
  assign addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_b = (opcode == OP_OP) ? rs2_v : imm_i;
    alu_y = '0;
    case (f3)
      3'b000: alu_y = (opcode == OP_OP && inst_q[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001: alu_y = rs1_v << alu_b[4:0];
      3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1_v < alu_b};
      3'b100: alu_y = rs1_v ^ alu_b;
      3'b101: alu_y = inst_q[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'b110: alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = (rs1_v == rs2_v);
      3'b001: taken = (rs1_v != rs2_v);
      3'b100: taken = ($signed(rs1_v) <  $signed(rs2_v));
      3'b101: taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110: taken = (rs1_v <  rs2_v);
      3'b111: taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_q + 32'd4;
    rd_data = alu_y;
    rd_wr   = 1'b0;
    case (opcode)
      OP_LUI:        begin rd_data = imm_u;         rd_wr = 1'b1; end
      OP_AUIPC:      begin rd_data = pc_q + imm_u;  rd_wr = 1'b1; end
      OP_JAL:        begin rd_data = pc_q + 32'd4;  rd_wr = 1'b1; pc_next = pc_q + imm_j; end
      OP_JALR:       begin rd_data = pc_q + 32'd4;  rd_wr = 1'b1;
                           pc_next = (rs1_v + imm_i) & ~32'd1; end
      OP_BR:         if (taken) pc_next = pc_q + imm_b;
      OP_IMM, OP_OP: rd_wr = 1'b1;
      default:       ;
    endcase
  end

  // RAM data is registered at the end of EXEC; the lane is extracted during LOAD.
  assign lane_b = data_out >> {addr[1:0], 3'b000};
  assign lane_h = data_out >> {addr[1], 4'b0000};

  always_comb begin
    case (f3)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b100:  ld_data = {24'b0, lane_b[7:0]};
      3'b101:  ld_data = {16'b0, lane_h[15:0]};
      default: ld_data = data_out;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00:   begin data_in = {4{rs2_v[7:0]}};  wr_mask = 4'b0001 << addr[1:0]; end
      2'b01:   begin data_in = {2{rs2_v[15:0]}}; wr_mask = 4'b0011 << {addr[1], 1'b0}; end
      default: begin data_in = rs2_v;            wr_mask = 4'b1111; end
    endcase
  end

  assign wr     = (state == LOAD) || (state == EXEC && rd_wr);
  assign rd_val = (state == LOAD) ? ld_data : rd_data;
  assign wr_en  = (state == EXEC) && (opcode == OP_STORE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= FETCH;
      pc_q   <= PC_RESET;
      inst_q <= NOP;
    end else begin
      case (state)
        FETCH: begin
          inst_q <= inst;
          state  <= EXEC;
        end
        EXEC: begin
          if (inst_q == EBREAK) begin
            state <= HALT;
          end else begin
            pc_q  <= pc_next;
            state <= (opcode == OP_LOAD) ? LOAD : FETCH;
          end
        end
        LOAD:    state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end
endmodule

module rv32i_soc_sys #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 8192,
  parameter int          RAM_DEPTH = 8192
) (
  input logic clk,
  input logic rst_n
);
  logic [31:0] pc, inst, addr, data_in, data_out;
  logic [3:0]  wr_mask;
  logic        wr_en;

  rv32i_core #(.PC_RESET(PC_RESET)) m0 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .addr(addr), .data_in(data_in),
    .wr_mask(wr_mask), .wr_en(wr_en), .data_out(data_out)
  );

  rv32i_rom #(.ROM_DEPTH(ROM_DEPTH)) m1 (.pc(pc), .inst(inst));

  rv32i_ram #(.RAM_DEPTH(RAM_DEPTH)) m2 (
    .clk(clk), .wr_en(wr_en), .addr(addr), .data_in(data_in), .wr_mask(wr_mask),
    .data_out(data_out)
  );
endmodule

// File: tb/tb_rv32i_soc_sys.sv
// Directed-program bench for rv32i_soc_sys: preloads ROM/RAM through hierarchy and
// checks architectural state against hand-computed results.
`timescale 1ns/1ps
module tb_rv32i_soc_sys;
  localparam logic [31:0] NOP = 32'h0000_0013, EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0, bad = 0;
  int wr_cnt = 0, we_cnt = 0, both_cnt = 0;
  logic [3:0]  masks [$];
  logic [31:0] prog  [$];

  rv32i_soc_sys dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (dut.m0.m0.wr === 1'b1) wr_cnt++;
    if (dut.m2.wr_en === 1'b1) begin
      we_cnt++;
      masks.push_back(dut.m2.wr_mask);
    end
    if (dut.m0.m0.wr === 1'b1 && dut.m2.wr_en === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins_i(int op, int rd, int f3, int rs1, int imm);
    logic [31:0] o = op, d = rd, f = f3, s = rs1, m = imm;
    return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] ins_r(int rd, int f3, int rs1, int rs2, int f7);
    logic [31:0] d = rd, f = f3, s = rs1, t = rs2, g = f7;
    return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] ins_s(int f3, int rs1, int rs2, int imm);
    logic [31:0] f = f3, s = rs1, t = rs2, m = imm;
    return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] ins_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] f = f3, s = rs1, t = rs2, m = imm;
    return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] ins_u(int op, int rd, int imm20);
    logic [31:0] o = op, d = rd, m = imm20;
    return {m[19:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] ins_j(int rd, int imm);
    logic [31:0] d = rd, m = imm;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] xr(int i);
    return dut.m0.m0.base_regfile[i];
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 64; i++) dut.m1.inst_regfile[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.m1.inst_regfile[i] = prog[i];
  endtask

  // Holds reset for 5 cycles, checks the reset state, releases and checks the first fetch.
  task automatic reset_and_start();
    int w0, e0;
    logic [31:0] acc;
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    e0 = we_cnt;
    repeat (5) @(negedge clk);
    check("rst_wr_pulses", wr_cnt - w0, 0);
    check("rst_wr_en_pulses", we_cnt - e0, 0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= xr(i);
    check("rst_regs_zero", acc, 0);
    check("rst_inst_q", dut.m0.inst_q, NOP);
    masks.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("first_fetch", dut.m0.inst_q, prog[0]);
  endtask

  task automatic run_to_halt();
    int n = 0;
    int w0, e0;
    while (dut.m0.inst_q !== EBREAK && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("halt_reached", dut.m0.inst_q, EBREAK);
    repeat (2) @(posedge clk);
    #1;
    w0 = wr_cnt;
    e0 = we_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("halt_no_wr", wr_cnt - w0, 0);
    check("halt_no_wr_en", we_cnt - e0, 0);
    check("halt_inst_q", dut.m0.inst_q, EBREAK);
  endtask

  initial begin
    int n;

    // ALU
    prog = '{ins_i('h13, 1, 0, 0, 5), ins_i('h13, 2, 0, 1, -7), ins_r(3, 3, 1, 2, 0),
             ins_i('h13, 4, 5, 2, 'h401), EBREAK};
    load_rom();
    reset_and_start();
    run_to_halt();
    check("alu_x1", xr(1), 32'h0000_0005);
    check("alu_x2", xr(2), 32'hFFFF_FFFE);
    check("alu_x3_sltu", xr(3), 32'h0000_0001);
    check("alu_x4_srai", xr(4), 32'hFFFF_FFFF);

    // Memory
    prog = '{ins_u('h37, 5, 1), ins_u('h37, 6, 'h12345), ins_i('h13, 6, 0, 6, 'h678),
             ins_s(2, 5, 6, 0), ins_i('h03, 11, 2, 5, 0), ins_i('h13, 7, 0, 0, 'hAB),
             ins_s(0, 5, 7, 1), ins_i('h03, 8, 0, 5, 1), ins_i('h03, 9, 4, 5, 1),
             ins_i('h03, 10, 1, 5, 2), ins_s(1, 5, 7, 6), ins_i('h03, 12, 5, 5, 6), EBREAK};
    load_rom();
    reset_and_start();
    run_to_halt();
    check("mem_x5_lui", xr(5), 32'h0000_1000);
    check("mem_lw_after_sw", xr(11), 32'h1234_5678);
    check("mem_word_0x400", dut.m2.data_regfile[12'h400], 32'h1234_AB78);
    check("mem_lb", xr(8), 32'hFFFF_FFAB);
    check("mem_lbu", xr(9), 32'h0000_00AB);
    check("mem_lh", xr(10), 32'h0000_1234);
    check("mem_lhu_0x1006", xr(12), 32'h0000_00AB);
    check("mem_store_count", masks.size(), 3);
    if (masks.size() == 3) begin
      check("mask_sw", {28'b0, masks[0]}, 32'hF);
      check("mask_sb_0x1001", {28'b0, masks[1]}, 32'h2);
      check("mask_sh_0x1006", {28'b0, masks[2]}, 32'hC);
    end

    // Control flow
    prog = '{ins_i('h13, 5, 0, 0, 1), ins_b(0, 5, 5, 8), ins_i('h13, 2, 0, 0, 99),
             ins_b(1, 5, 5, 8), ins_j(1, 8), ins_i('h13, 2, 0, 0, 77),
             ins_i('h13, 6, 0, 0, 'h25), ins_i('h67, 7, 0, 6, 0), ins_i('h13, 2, 0, 0, 55),
             ins_u('h17, 3, 0), EBREAK};
    load_rom();
    reset_and_start();
    run_to_halt();
    check("cf_skipped_writes_x2", xr(2), 32'h0);
    check("cf_jal_link", xr(1), 32'h0000_0014);
    check("cf_jalr_link", xr(7), 32'h0000_0020);
    check("cf_jalr_bit0_clear", xr(3), 32'h0000_0024);

    // Compliance-style exit, passing and failing codes
    prog = '{ins_i('h13, 17, 0, 0, 'h5d), ins_i('h13, 10, 0, 0, 0), EBREAK};
    load_rom();
    reset_and_start();
    run_to_halt();
    check("exit_x17", xr(17), 32'h0000_005d);
    check("exit_x10_pass", xr(10), 32'h0);
    $display("compliance exit: x17=%h x10=%h", xr(17), xr(10));
    prog = '{ins_i('h13, 17, 0, 0, 'h5d), ins_i('h13, 10, 0, 0, 7), EBREAK};
    load_rom();
    reset_and_start();
    run_to_halt();
    check("exit_code", xr(10) >> 1, 32'd3);
    $display("compliance exit: code=%0d", xr(10) >> 1);

    // Mid-run reset during a LOAD write-back
    dut.m2.data_regfile[12'h400] = 32'hCAFE_F00D;
    prog = '{ins_i('h13, 1, 0, 0, 9), ins_u('h37, 5, 1), ins_i('h03, 11, 2, 5, 0), EBREAK};
    load_rom();
    reset_and_start();
    n = 0;
    while (!(dut.m0.m0.wr === 1'b1 && dut.m0.m0.rd_addr == 5'd11) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrun_load_seen", {31'b0, n < 200}, 32'd1);
    rst_n = 1'b1;
    #1;
    check("midrun_wr_aborted", {31'b0, dut.m0.m0.wr}, 32'd0);
    @(posedge clk);
    #1;
    check("midrun_x11_suppressed", xr(11), 32'h0);
    check("midrun_x1_cleared", xr(1), 32'h0);
    reset_and_start();
    run_to_halt();
    check("rerun_x1", xr(1), 32'h0000_0009);
    check("rerun_x11", xr(11), 32'hCAFE_F00D);

    check("wr_and_wr_en_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
